// File: rtl/cache_pkg.sv
// Shared definitions for the cache line-fill server: FSM encoding,
// burst geometry and the critical-word-first index helper.
package cache_pkg;

   // Words per cacheline; the counters and buffer are sized for exactly 4.
   localparam int BURST_WORDS = 4;

   // Width of one memory / cache data word.
   localparam int WORD_W = 16;

   // Fill sequencer states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      COLLECT = 2'd2,
      STREAM  = 2'd3
   } state_t;

   // Buffer slot delivered in stream cycle k when the critical word is crit.
   // The 2-bit sum wraps modulo 4, giving the critical-word-first order.
   function automatic logic [1:0] stream_idx(input logic [1:0] crit,
                                             input logic [1:0] k);
      return crit + k;
   endfunction

endpackage

// File: rtl/cache_fill_server_if.sv
// Cache-side and memory-side signals of the line-fill server.
// Handshakes:
//   cache_req is held high by the cache until it sees the one-cycle
//   cache_fill strobe; cache_data then carries 4 words on consecutive
//   cycles starting with the fill strobe cycle.
//   mem_req is held (with mem_addr stable) until mem_ack is high on a rising
//   edge; afterwards each mem_valid cycle transfers one mem_data word,
//   ascending order, arbitrary spacing.
// The server side uses modport slave, the cache/memory environment master.
interface cache_fill_server_if #(
   parameter int ADDR_W = 25
);
   logic              cache_req;
   logic [ADDR_W-1:0] cache_addr;
   logic              cache_fill;
   logic [15:0]       cache_data;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic              mem_valid;
   logic [15:0]       mem_data;

   modport slave (
      input  cache_req, cache_addr, mem_ack, mem_valid, mem_data,
      output cache_fill, cache_data, mem_req, mem_addr
   );

   modport master (
      output cache_req, cache_addr, mem_ack, mem_valid, mem_data,
      input  cache_fill, cache_data, mem_req, mem_addr
   );

endinterface

// File: rtl/fill_line_buffer.sv
// 4 x 16-bit line buffer: one synchronous write port filled in arrival
// order, one asynchronous read port used while streaming. Contents are
// never reset; every slot is rewritten before it is read in a fill.
module fill_line_buffer
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              we_i,
   input  logic [1:0]        wr_idx_i,
   input  logic [WORD_W-1:0] wr_data_i,
   input  logic [1:0]        rd_idx_i,
   output logic [WORD_W-1:0] rd_data_o
);

   logic [WORD_W-1:0] mem_q [BURST_WORDS];

   // Capture one memory word into the slot selected by the write counter.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/cache_fill_server.sv
// Cache line-fill server: takes a miss request, fetches the aligned 4-word
// line from memory, then streams it back critical word first.
// Flow: IDLE -> ISSUE (mem_req held until mem_ack) -> COLLECT (4 words
// into the line buffer) -> STREAM (4 cycles, cache_fill on the first).
module cache_fill_server
   import cache_pkg::*;
#(
   parameter int ADDR_W = 25,
   parameter int BURST  = BURST_WORDS
) (
   input  logic        clk,
   input  logic        reset,
   cache_fill_server_if.slave fill_if,
   output logic        busy,
   output state_t      dbg_state
);

   // Last index of the 2-bit word counters.
   localparam logic [1:0] LAST_IDX = 2'(BURST - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        wcnt_q, wcnt_d;
   logic [1:0]        kcnt_q, kcnt_d;
   logic [15:0]       data_hold_q, data_hold_d;
   logic              buf_we;
   logic [1:0]        rd_idx;
   logic [15:0]       rd_data;

   fill_line_buffer u_buf (
      .clk       (clk),
      .we_i      (buf_we),
      .wr_idx_i  (wcnt_q),
      .wr_data_i (fill_if.mem_data),
      .rd_idx_i  (rd_idx),
      .rd_data_o (rd_data)
   );

   // State, latched address, counters and the cache_data hold register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wcnt_q      <= '0;
         kcnt_q      <= '0;
         data_hold_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wcnt_q      <= wcnt_d;
         kcnt_q      <= kcnt_d;
         data_hold_q <= data_hold_d;
      end
   end

   // Next-state logic; requests, acks and data are only honoured in the
   // state that expects them, everything else is dropped.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wcnt_d  = wcnt_q;
      kcnt_d  = kcnt_q;
      buf_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (fill_if.cache_req) begin
               addr_d  = fill_if.cache_addr;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (fill_if.mem_ack) begin
               wcnt_d  = '0;
               state_d = COLLECT;
            end
         end
         COLLECT: begin
            if (fill_if.mem_valid) begin
               buf_we = 1'b1;
               wcnt_d = wcnt_q + 2'd1;
               if (wcnt_q == LAST_IDX) begin
                  kcnt_d  = '0;
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            kcnt_d = kcnt_q + 2'd1;
            if (kcnt_q == LAST_IDX) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Read side: critical-word-first slot, and the last streamed word is
   // retained so cache_data holds steady between fills.
   always_comb begin
      rd_idx      = stream_idx(addr_q[1:0], kcnt_q);
      data_hold_d = (state_q == STREAM) ? rd_data : data_hold_q;
   end

   assign fill_if.mem_req    = (state_q == ISSUE);
   assign fill_if.mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
   assign fill_if.cache_fill = (state_q == STREAM) && (kcnt_q == 2'd0);
   assign fill_if.cache_data = (state_q == STREAM) ? rd_data : data_hold_q;
   assign busy               = (state_q != IDLE);
   assign dbg_state          = state_q;

endmodule

// File: tb/tb_cache_fill_server.sv
// Directed bench for cache_fill_server: each fill is driven cycle by
// cycle, expected stream words are queued by hand and popped per cycle.
module tb_cache_fill_server;
   import cache_pkg::*;

   localparam int ADDR_W = 25;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cache_fill_server_if #(.ADDR_W(ADDR_W)) fif ();
   logic   busy;
   state_t dbg_state;

   cache_fill_server #(.ADDR_W(ADDR_W), .BURST(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .fill_if   (fif),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // words: {w3,w2,w1,w0} in arrival order; expd: {e3,e2,e1,e0} stream order;
   // gaps: idle cycles before word j in nibble j.
   task automatic do_fill(input string name, input logic [ADDR_W-1:0] addr,
                          input logic [ADDR_W-1:0] exp_maddr, input int ack_dly,
                          input logic [63:0] words, input logic [15:0] gaps,
                          input logic [63:0] expd, input bit spur,
                          input bit toggle, input bit keep);
      logic [15:0] last;
      last = '0;
      for (int j = 0; j < 4; j++) exp_q.push_back(expd[j*16 +: 16]);
      if (spur) begin
         fif.mem_valid = 1'b1;
         fif.mem_data  = 16'hDEAD;
         tick();
         check({name, " idle_busy"}, 32'(busy), 32'd0);
         fif.mem_valid = 1'b0;
      end
      fif.cache_req  = 1'b1;
      fif.cache_addr = addr;
      tick();
      check({name, " issue_state"}, 32'(dbg_state), 32'(ISSUE));
      check({name, " mem_req"}, 32'(fif.mem_req), 32'd1);
      check({name, " mem_addr"}, 32'(fif.mem_addr), 32'(exp_maddr));
      check({name, " busy"}, 32'(busy), 32'd1);
      for (int i = 0; i < ack_dly; i++) begin
         if (spur) begin
            fif.mem_valid = 1'b1;
            fif.mem_data  = 16'hBEEF;
         end
         tick();
         fif.mem_valid = 1'b0;
         check({name, " mem_req_hold"}, 32'(fif.mem_req), 32'd1);
         check({name, " mem_addr_hold"}, 32'(fif.mem_addr), 32'(exp_maddr));
      end
      fif.mem_ack = 1'b1;
      tick();
      fif.mem_ack = 1'b0;
      check({name, " mem_req_drop"}, 32'(fif.mem_req), 32'd0);
      check({name, " collect_state"}, 32'(dbg_state), 32'(COLLECT));
      for (int j = 0; j < 4; j++) begin
         for (int g = 0; g < int'(gaps[j*4 +: 4]); g++) begin
            tick();
            check({name, " no_early_fill"}, 32'(fif.cache_fill), 32'd0);
         end
         fif.mem_valid = 1'b1;
         fif.mem_data  = words[j*16 +: 16];
         tick();
         fif.mem_valid = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
         last = exp_q.pop_front();
         check($sformatf("%s fill_k%0d", name, k), 32'(fif.cache_fill), (k == 0) ? 32'd1 : 32'd0);
         check($sformatf("%s data_k%0d", name, k), 32'(fif.cache_data), 32'(last));
         check($sformatf("%s busy_k%0d", name, k), 32'(busy), 32'd1);
         if (!keep) fif.cache_req = toggle && (k == 0 || k == 2);
         tick();
      end
      check({name, " end_busy"}, 32'(busy), 32'd0);
      check({name, " end_fill"}, 32'(fif.cache_fill), 32'd0);
      check({name, " end_mem_req"}, 32'(fif.mem_req), 32'd0);
      check({name, " data_hold"}, 32'(fif.cache_data), 32'(last));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset          = 1'b1;
      fif.cache_req  = 1'b0;
      fif.cache_addr = '0;
      fif.mem_ack    = 1'b0;
      fif.mem_valid  = 1'b0;
      fif.mem_data   = '0;
      tick();
      tick();
      check("rst state", 32'(dbg_state), 32'(IDLE));
      check("rst busy", 32'(busy), 32'd0);
      check("rst mem_req", 32'(fif.mem_req), 32'd0);
      check("rst fill", 32'(fif.cache_fill), 32'd0);
      check("rst data", 32'(fif.cache_data), 32'd0);
      check("rst mem_addr", 32'(fif.mem_addr), 32'd0);
      reset = 1'b0;
      tick();

      // critical word 2, ack after 3 waiting cycles, back-to-back words
      do_fill("crit2", 25'h0000102, 25'h0000100, 3, 64'h00A3_00A2_00A1_00A0,
              16'h0000, 64'h00A1_00A0_00A3_00A2, 1'b0, 1'b0, 1'b0);
      // critical word 0, words at cycles 1,4,5,9 after the ack
      do_fill("gapped", 25'h0000340, 25'h0000340, 1, 64'h0044_0033_0022_0011,
              16'h3020, 64'h0044_0033_0022_0011, 1'b0, 1'b0, 1'b0);
      // critical word 3 wraps around
      do_fill("crit3", 25'h1ABCDEF, 25'h1ABCDEC, 0, 64'h00C3_00C2_00C1_00C0,
              16'h0000, 64'h00C2_00C1_00C0_00C3, 1'b0, 1'b0, 1'b0);

      // reset during COLLECT after two words
      fif.cache_req  = 1'b1;
      fif.cache_addr = 25'h0000201;
      tick();
      fif.mem_ack = 1'b1;
      tick();
      fif.mem_ack   = 1'b0;
      fif.mem_valid = 1'b1;
      fif.mem_data  = 16'h0099;
      tick();
      fif.mem_data  = 16'h0098;
      tick();
      fif.mem_valid = 1'b0;
      check("mid_rst collect", 32'(dbg_state), 32'(COLLECT));
      reset = 1'b1;
      #1;
      check("mid_rst state", 32'(dbg_state), 32'(IDLE));
      check("mid_rst busy", 32'(busy), 32'd0);
      check("mid_rst fill", 32'(fif.cache_fill), 32'd0);
      check("mid_rst data", 32'(fif.cache_data), 32'd0);
      check("mid_rst mem_req", 32'(fif.mem_req), 32'd0);
      fif.cache_req = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      check("post_rst idle", 32'(busy), 32'd0);
      do_fill("after_rst", 25'h0000201, 25'h0000200, 1, 64'h00B3_00B2_00B1_00B0,
              16'h0000, 64'h00B0_00B3_00B2_00B1, 1'b0, 1'b0, 1'b0);

      // spurious mem_valid in IDLE/ISSUE, cache_req toggled while streaming
      do_fill("spur", 25'h0000055, 25'h0000054, 2, 64'h00D3_00D2_00D1_00D0,
              16'h0000, 64'h00D0_00D3_00D2_00D1, 1'b1, 1'b1, 1'b0);
      tick();
      check("spur no_extra_fill", 32'(busy), 32'd0);

      // cache_req held high across two fills
      do_fill("b2b_1", 25'h0000010, 25'h0000010, 1, 64'h00E3_00E2_00E1_00E0,
              16'h0000, 64'h00E3_00E2_00E1_00E0, 1'b0, 1'b0, 1'b1);
      do_fill("b2b_2", 25'h0000013, 25'h0000010, 1, 64'h00F3_00F2_00F1_00F0,
              16'h0000, 64'h00F2_00F1_00F0_00F3, 1'b0, 1'b0, 1'b0);
      tick();
      check("final idle", 32'(dbg_state), 32'(IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cache_fill_server.md
CACHE_FILL_SERVER -- requirements
Module: cache_fill_server

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, meaning the word-address width (bits 25:1 of the byte address).
REQ-002 SHALL have parameter BURST, default 4 (fixed), meaning the words per cacheline; other values are unsupported.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port cache_req, input, 1, the line-fill request; held high by the cache until it sees cache_fill.
REQ-006 SHALL have port cache_addr, input, ADDR_W, the word address of the missed word; [1:0] is the critical word.
REQ-007 SHALL have port cache_fill, output, 1, a one-cycle strobe marking the first (critical) word on cache_data.
REQ-008 SHALL have port cache_data, output, 16, the burst data, one word per cycle for 4 cycles starting at cache_fill.
REQ-009 SHALL have port mem_req, output, 1, the memory read request, held until accepted.
REQ-010 SHALL have port mem_addr, output, ADDR_W, the line-aligned word address ({cache_addr[ADDR_W-1:2],2'b00}).
REQ-011 SHALL have port mem_ack, input, 1, the memory accept strobe for mem_req.
REQ-012 SHALL have port mem_valid, input, 1, a qualifier for mem_data; words arrive in ascending order, any spacing.
REQ-013 SHALL have port mem_data, input, 16, the memory read data.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL implement the states IDLE, ISSUE, COLLECT and STREAM.
REQ-016 IDLE: on cache_req=1, SHALL latch cache_addr, set mem_req=1 and go to ISSUE; otherwise SHALL remain in IDLE.
REQ-017 ISSUE: SHALL hold mem_req and mem_addr stable until mem_ack=1, then drop mem_req the same edge and go to COLLECT.
REQ-018 COLLECT: each mem_valid=1 SHALL write mem_data into line buffer slot wcnt, then increment the 2-bit wcnt.
REQ-019 On the 4th mem_valid SHALL go to STREAM; the first STREAM cycle drives cache_fill=1 with the critical word (latency 1 clock after the last capture).
REQ-020 STREAM: cycle k (k=0..3) SHALL drive cache_data=buffer[(crit+k) mod 4], with wrap-around modulo 4; cache_fill SHALL be 1 only at k=0; after k=3 go to IDLE.
REQ-021 mem_valid outside COLLECT SHALL be ignored; mem_ack outside ISSUE SHALL be ignored.
REQ-022 cache_req SHALL be sampled only in IDLE; a request arriving during a fill is not queued.
REQ-023 cache_req still high in the cycle after STREAM ends SHALL start a new fill (the cache is responsible for dropping it).
REQ-024 mem_ack and the 4th mem_valid in the same cycle SHALL be impossible by protocol; mem_valid in ISSUE SHALL be discarded.
REQ-025 cache_data outside STREAM SHALL hold its last value; only cache_fill qualifies it.
REQ-026 wcnt SHALL clear to 0 on entry to COLLECT.

Reset
REQ-027 Asserting reset at any time SHALL force IDLE with mem_req=0, cache_fill=0, busy=0, cache_data=0, wcnt=0 and latched address 0.
REQ-028 Reset mid-burst SHALL abandon the fill with no partial STREAM output; the memory side shares this reset.
REQ-029 The line buffer contents need no reset.

Structure
REQ-030 The state encoding and the BURST_WORDS=4 constant SHALL live in the shared package cache_pkg.
REQ-031 The 4x16 buffer (write index, read index) SHALL be one sub-module, fill_line_buffer; the FSM and counters stay in the top.
REQ-032 Expected size: 150-250 lines of RTL.

Verification
REQ-033 With cache_addr=0x0000102, mem_ack 3 cycles after the request and words 0xA0..0xA3 back-to-back: mem_addr=0x0000100; cache_data SHALL be A2,A3,A0,A1 with cache_fill on A2.
REQ-034 With crit=0 and mem_valid gapped (cycles 1,4,5,9): cache_fill SHALL appear exactly 1 clock after the 4th capture, with order w0..w3.
REQ-035 With crit=3: cache_data SHALL be w3,w0,w1,w2 (wrap check), busy low the cycle after w2.
REQ-036 Reset asserted during COLLECT after 2 words: outputs SHALL be 0 immediately; a next request (crit=1) SHALL yield a correct full burst and no stale words.
REQ-037 With spurious mem_valid in IDLE and in ISSUE, and cache_req toggled during STREAM: no buffer corruption, no extra fill, exactly 4 data cycles.
REQ-038 With cache_req held high for two back-to-back requests: SHALL yield two complete fills with mem_req re-asserted the cycle after the first STREAM ends.
